rr_stream_arbiter2: RTL and testbench

//   Two-input round-robin stream arbiter that sits directly upstream of the 2:1 mux.
//   It picks one of two valid/ready sources and drives the mux select.
//   It registers the winning word into a one-entry output stage, so the downstream

---
 rtl/rr_stream_arbiter2.sv | 81 ++++++++
 tb/tb_rr_stream_arbiter2.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_arbiter2.sv
// Two-input round-robin valid/ready arbiter with a one-entry registered output stage.
// select_line is registered alongside out_data and names the source of the held word.
module rr_stream_arbiter2 #(
    parameter int DATA_W = 8,
    parameter int BURST  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              select_line
);

    localparam int CNT_W = (BURST < 1) ? 1 : $clog2(BURST + 1);
    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

    logic             last;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             grant_any;
    logic             grant;
    logic             xfer;

    assign load = !out_valid || out_ready;

    // Readies are held low while reset is asserted, so nothing is handed off into a stage being cleared.
    always_comb begin
        grant_any = 1'b0;
        grant     = 1'b0;
        if (rst_n && load) begin
            if (in0_valid && in1_valid) begin
                grant_any = 1'b1;
                grant     = (cnt < BURST_C) ? last : ~last;
            end else if (in0_valid) begin
                grant_any = 1'b1;
                grant     = 1'b0;
            end else if (in1_valid) begin
                grant_any = 1'b1;
                grant     = 1'b1;
            end
        end
    end

    assign in0_ready = grant_any && !grant;
    assign in1_ready = grant_any && grant;
    assign xfer      = grant_any;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            select_line <= 1'b0;
            last        <= 1'b1;
            cnt         <= '0;
        end else if (load) begin
            if (xfer) begin
                out_valid   <= 1'b1;
                out_data    <= grant ? in1_data : in0_data;
                select_line <= grant;
                if (grant == last) begin
                    if (cnt < BURST_C) begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    last <= grant;
                    cnt  <= CNT_W'(1);
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_stream_arbiter2.sv
// Bench for rr_stream_arbiter2: BURST=2 and BURST=1 instances share stimulus,
// each checked against its own rule-level reference model, plus directed scenarios.
module tb_rr_stream_arbiter2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v0, v1, ordy;
    logic [7:0] d0, d1;

    logic       r0_a, r1_a, ov_a, sel_a;
    logic [7:0] od_a;
    logic       r0_b, r1_b, ov_b, sel_b;
    logic [7:0] od_b;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    always #5 clk = ~clk;

    rr_stream_arbiter2 #(.DATA_W(8), .BURST(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(v0), .in0_data(d0), .in0_ready(r0_a),
        .in1_valid(v1), .in1_data(d1), .in1_ready(r1_a),
        .out_valid(ov_a), .out_data(od_a), .out_ready(ordy), .select_line(sel_a)
    );

    rr_stream_arbiter2 #(.DATA_W(8), .BURST(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(v0), .in0_data(d0), .in0_ready(r0_b),
        .in1_valid(v1), .in1_data(d1), .in1_ready(r1_b),
        .out_valid(ov_b), .out_data(od_b), .out_ready(ordy), .select_line(sel_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: k=0 mirrors dut_a (burst 2), k=1 mirrors dut_b (burst 1).
    int m_valid[2], m_data[2], m_sel[2], m_last[2], m_cnt[2];
    int burst[2] = '{2, 1};

    function automatic int m_grant(input int k);
        bit ld;
        ld = (m_valid[k] == 0) || ordy;
        if (!rst_n || !ld) return -1;
        if (v0 && v1) return (m_cnt[k] < burst[k]) ? m_last[k] : 1 - m_last[k];
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        int g[2];
        for (int k = 0; k < 2; k++) g[k] = m_grant(k);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_valid[k] = 0; m_data[k] = 0; m_sel[k] = 0; m_last[k] = 1; m_cnt[k] = 0;
            end else if (m_valid[k] == 0 || ordy) begin
                if (g[k] >= 0) begin
                    m_valid[k] = 1;
                    m_data[k]  = (g[k] == 1) ? int'(d1) : int'(d0);
                    m_sel[k]   = g[k];
                    if (g[k] == m_last[k]) m_cnt[k] = (m_cnt[k] + 1 > burst[k]) ? burst[k] : m_cnt[k] + 1;
                    else begin
                        m_last[k] = g[k];
                        m_cnt[k]  = 1;
                    end
                end else begin
                    m_valid[k] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            int ga, gb;
            ga = m_grant(0);
            gb = m_grant(1);
            chk("a_out_valid", ov_a, m_valid[0]);
            chk("a_out_data", od_a, m_data[0]);
            chk("a_select", sel_a, m_sel[0]);
            chk("a_in0_ready", r0_a, ga == 0);
            chk("a_in1_ready", r1_a, ga == 1);
            chk("b_out_valid", ov_b, m_valid[1]);
            chk("b_out_data", od_b, m_data[1]);
            chk("b_select", sel_b, m_sel[1]);
            chk("b_in0_ready", r0_b, gb == 0);
            chk("b_in1_ready", r1_b, gb == 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic exp_a[6];
        logic exp_b[6];
        logic [7:0] ea, eb;
        exp_a = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_b = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1; d0 = 8'h11; d1 = 8'h22; ordy = 1'b1;
        // reset with both sources valid
        step();
        mon_on = 1'b1;
        step();
        chk("rst_out_valid", ov_a, 0);
        chk("rst_out_data", od_a, 8'h00);
        chk("rst_select", sel_a, 0);
        chk("rst_in0_ready", r0_a, 0);
        chk("rst_in1_ready", r1_a, 0);
        rst_n = 1'b1;

        // single source stream
        v1 = 1'b0; v0 = 1'b1; d0 = 8'hA1;
        step(); chk("single_d1", od_a, 8'hA1); chk("single_s1", sel_a, 0); chk("single_v1", ov_a, 1);
        d0 = 8'hA2;
        step(); chk("single_d2", od_a, 8'hA2); chk("single_s2", sel_a, 0);
        d0 = 8'hA3;
        step(); chk("single_d3", od_a, 8'hA3); chk("single_s3", sel_a, 0);
        v0 = 1'b0;
        step(); chk("single_drain", ov_a, 0);

        // continuous tie: burst 2 and burst 1 orders
        do_reset();
        v0 = 1'b1; v1 = 1'b1; d0 = 8'h10; d1 = 8'h20; ordy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ea = exp_a[i] ? d1 : d0;
            eb = exp_b[i] ? d1 : d0;
            step();
            chk("tie_sel_a", sel_a, exp_a[i]);
            chk("tie_sel_b", sel_b, exp_b[i]);
            chk("tie_data_a", od_a, ea);
            chk("tie_data_b", od_b, eb);
            d0 = d0 + 8'd1;
            d1 = d1 + 8'd1;
        end

        // backpressure holds the word and blocks both sources
        do_reset();
        v1 = 1'b0; v0 = 1'b1; d0 = 8'h55; ordy = 1'b1;
        step();
        ordy = 1'b0; d0 = 8'h66; v1 = 1'b1; d1 = 8'h77;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_data", od_a, 8'h55);
            chk("bp_valid", ov_a, 1);
            chk("bp_r0", r0_a, 0);
            chk("bp_r1", r1_a, 0);
        end
        v1 = 1'b0; ordy = 1'b1;
        #1;
        chk("bp_release_r0", r0_a, 1);
        step();
        chk("bp_next_data", od_a, 8'h66);
        chk("bp_next_sel", sel_a, 0);

        // reset mid-stream, then the first tie goes to source 1
        v0 = 1'b1; v1 = 1'b1;
        step();
        step();
        chk("mid_pre_valid", ov_a, 1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid_a", ov_a, 0);
        chk("mid_rst_valid_b", ov_b, 0);
        rst_n = 1'b1;
        d0 = 8'h3C; d1 = 8'hC3;
        step();
        chk("mid_tie_sel_a", sel_a, 1);
        chk("mid_tie_sel_b", sel_b, 1);
        chk("mid_tie_data", od_a, 8'hC3);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            v0    = ($urandom_range(3) != 0);
            v1    = ($urandom_range(3) != 0);
            ordy  = ($urandom_range(3) != 0);
            d0    = 8'($urandom);
            d1    = 8'($urandom);
            rst_n = ($urandom_range(99) != 0);
            step();
        end
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
